// File: rtl/sr_latch_pkg.sv
// sr_latch_pkg: conflict-policy encodings shared by sr_latch and sr_cell
package sr_latch_pkg;
  typedef logic [1:0] sr_policy_t;
  localparam sr_policy_t SR_HOLD     = 2'd0;
  localparam sr_policy_t SR_SET_WINS = 2'd1;
  localparam sr_policy_t SR_RST_WINS = 2'd2;
  localparam sr_policy_t SR_TOGGLE   = 2'd3;
  function automatic sr_policy_t to_policy(input int p);
    return (p < 0 || p > 3) ? SR_HOLD : sr_policy_t'(p);
  endfunction
endpackage

// File: rtl/sr_cell.sv
// sr_cell: one clocked SR bit with compile-time conflict policy and registered conflict flag
module sr_cell
  import sr_latch_pkg::*;
#(
  parameter logic       RESET_VAL = 1'b0,
  parameter sr_policy_t POLICY    = SR_HOLD
) (
  input  logic clk,
  input  logic reset,
  input  logic s,
  input  logic r,
  output logic q,
  output logic illegal
);
  logic q_q, q_d, illegal_q, illegal_d, both, conf_q;
  always_comb begin
    both      = s & r;
    conf_q    = POLICY == SR_SET_WINS ? 1'b1 :
                POLICY == SR_RST_WINS ? 1'b0 :
                POLICY == SR_TOGGLE   ? ~q_q : q_q;
    q_d       = reset ? RESET_VAL : both ? conf_q : s ? 1'b1 : r ? 1'b0 : q_q;
    illegal_d = ~reset & both;
  end
  always_ff @(posedge clk) begin
    q_q       <= q_d;
    illegal_q <= illegal_d;
  end
  assign q       = q_q;
  assign illegal = illegal_q;
endmodule

// File: rtl/sr_latch.sv
// sr_latch: WIDTH independent clocked SR bits; SR_LATCH_ERR_STICKY_EN adds sticky conflict flag err
module sr_latch
  import sr_latch_pkg::*;
#(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VAL   = '0,
  parameter int               BOTH_POLICY = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
`ifdef SR_LATCH_ERR_STICKY_EN
  output logic             err,
`endif
  output logic [WIDTH-1:0] illegal
);
  localparam sr_policy_t POLICY = to_policy(BOTH_POLICY);
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    sr_cell #(.RESET_VAL(RESET_VAL[i]), .POLICY(POLICY)) u_cell (
      .clk(clk), .reset(reset), .s(s[i]), .r(r[i]), .q(q[i]), .illegal(illegal[i])
    );
  end
  assign qn = ~q;
`ifdef SR_LATCH_ERR_STICKY_EN
  logic err_q, err_d;
  always_comb err_d = reset ? 1'b0 : err_q | (|(s & r));
  always_ff @(posedge clk) err_q <= err_d;
  assign err = err_q;
`endif
endmodule

// File: tb/tb_sr_latch.sv
// tb_sr_latch: directed vectors for five policy/reset variants, scoreboard-checked one edge later
module tb_sr_latch;
  logic clk = 0, reset = 0;
  logic [3:0] s = '0, r = '0;
  logic [3:0] q[5], qn[5], ill[5];
  logic       err[5];
  int n_tests = 0, n_fail = 0;
  bit done = 0;

  typedef struct {
    string      name;
    logic [3:0] q[5];
    logic [3:0] ill;
    logic       err;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

`ifdef SR_LATCH_ERR_STICKY_EN
  sr_latch #(.WIDTH(4), .RESET_VAL(4'b0000), .BOTH_POLICY(0)) u0 (.clk(clk), .reset(reset), .s(s), .r(r), .q(q[0]), .qn(qn[0]), .err(err[0]), .illegal(ill[0]));
  sr_latch #(.WIDTH(4), .RESET_VAL(4'b0000), .BOTH_POLICY(1)) u1 (.clk(clk), .reset(reset), .s(s), .r(r), .q(q[1]), .qn(qn[1]), .err(err[1]), .illegal(ill[1]));
  sr_latch #(.WIDTH(4), .RESET_VAL(4'b0000), .BOTH_POLICY(2)) u2 (.clk(clk), .reset(reset), .s(s), .r(r), .q(q[2]), .qn(qn[2]), .err(err[2]), .illegal(ill[2]));
  sr_latch #(.WIDTH(4), .RESET_VAL(4'b1001), .BOTH_POLICY(3)) u3 (.clk(clk), .reset(reset), .s(s), .r(r), .q(q[3]), .qn(qn[3]), .err(err[3]), .illegal(ill[3]));
  sr_latch #(.WIDTH(4), .RESET_VAL(4'b0000), .BOTH_POLICY(5)) u4 (.clk(clk), .reset(reset), .s(s), .r(r), .q(q[4]), .qn(qn[4]), .err(err[4]), .illegal(ill[4]));
`else
  sr_latch #(.WIDTH(4), .RESET_VAL(4'b0000), .BOTH_POLICY(0)) u0 (.clk(clk), .reset(reset), .s(s), .r(r), .q(q[0]), .qn(qn[0]), .illegal(ill[0]));
  sr_latch #(.WIDTH(4), .RESET_VAL(4'b0000), .BOTH_POLICY(1)) u1 (.clk(clk), .reset(reset), .s(s), .r(r), .q(q[1]), .qn(qn[1]), .illegal(ill[1]));
  sr_latch #(.WIDTH(4), .RESET_VAL(4'b0000), .BOTH_POLICY(2)) u2 (.clk(clk), .reset(reset), .s(s), .r(r), .q(q[2]), .qn(qn[2]), .illegal(ill[2]));
  sr_latch #(.WIDTH(4), .RESET_VAL(4'b1001), .BOTH_POLICY(3)) u3 (.clk(clk), .reset(reset), .s(s), .r(r), .q(q[3]), .qn(qn[3]), .illegal(ill[3]));
  sr_latch #(.WIDTH(4), .RESET_VAL(4'b0000), .BOTH_POLICY(5)) u4 (.clk(clk), .reset(reset), .s(s), .r(r), .q(q[4]), .qn(qn[4]), .illegal(ill[4]));
  assign err = '{default: 1'b0};
`endif

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Monitor: outputs settle one edge after the vector was driven
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      for (int i = 0; i < 5; i++) begin
        chk($sformatf("%s q[u%0d]", e.name, i), q[i], e.q[i]);
        chk($sformatf("%s qn[u%0d]", e.name, i), qn[i], ~e.q[i]);
        chk($sformatf("%s illegal[u%0d]", e.name, i), ill[i], e.ill);
`ifdef SR_LATCH_ERR_STICKY_EN
        chk($sformatf("%s err[u%0d]", e.name, i), {3'b000, err[i]}, {3'b000, e.err});
`endif
      end
    end
  end

  logic err_m = 0;
  task automatic step(input string name, input logic rst, input logic [3:0] sv, input logic [3:0] rv,
                      input logic [3:0] e0, input logic [3:0] e1, input logic [3:0] e2,
                      input logic [3:0] e3, input logic [3:0] e4, input logic [3:0] eill);
    exp_t e;
    @(negedge clk);
    reset = rst; s = sv; r = rv;
    err_m = rst ? 1'b0 : err_m | (|(sv & rv));
    e.name = name;
    e.q[0] = e0; e.q[1] = e1; e.q[2] = e2; e.q[3] = e3; e.q[4] = e4;
    e.ill = eill; e.err = err_m;
    sb.push_back(e);
  endtask

  initial begin
    //    name           rst s        r        u0(hold) u1(set)  u2(rst)  u3(tog)  u4(bad->hold) illegal
    step("reset",        1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1001, 4'b0000, 4'b0000);
    step("set1",         0, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b1001, 4'b0001, 4'b0000);
    step("set2",         0, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b1001, 4'b0001, 4'b0000);
    step("hold1",        0, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b1001, 4'b0001, 4'b0000);
    step("hold2",        0, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b1001, 4'b0001, 4'b0000);
    step("clear",        0, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0000);
    step("conflict1",    0, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b1001, 4'b0000, 4'b0001);
    step("conflict2",    0, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b1000, 4'b0000, 4'b0001);
    step("idle",         0, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b1000, 4'b0000, 4'b0000);
    step("rst_conflict", 1, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b1001, 4'b0000, 4'b0000);
    step("mixed",        0, 4'b0101, 4'b0011, 4'b0100, 4'b0101, 4'b0100, 4'b1100, 4'b0100, 4'b0001);
    step("all_set",      0, 4'b1111, 4'b0000, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b0000);
    step("all_conf",     0, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b1111, 4'b1111);
    step("part_clr",     0, 4'b0000, 4'b1010, 4'b0101, 4'b0101, 4'b0000, 4'b0000, 4'b0101, 4'b0000);
    step("indep",        0, 4'b1010, 4'b0101, 4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b0000);
    step("reset_end",    1, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b1001, 4'b0000, 4'b0000);
    @(negedge clk);
    reset = 0; s = '0; r = '0;
    done = 1;
  end

  initial begin
    wait (done);
    repeat (3) @(posedge clk);
    #2;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete, expected completion");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
